// File: rtl/silc_core_param.sv
`default_nettype none
// ============================================================================
//  Module   : silc_core_param
//  Purpose  : Parametrised SILC authenticated encryption / decryption
//             controller driving one external block cipher through a
//             load / done handshake. Handles AD, message, partial final
//             blocks, tag generation and tag checking.
//  Revision : 1.0 - initial parametrised release (generic width, decrypt)
// ============================================================================
module silc_core_param #(
  parameter int BLK_W = 64,
  parameter int LEN_W = 64,
  parameter int TAG_W = 64,
  parameter int NB_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             decrypt,
  input  logic [BLK_W-1:0] din,
  input  logic [NB_W-1:0]  din_bytes,
  input  logic [TAG_W-1:0] tag_in,
  output logic [BLK_W-1:0] dout,
  output logic             dout_valid,
  output logic             done,
  output logic             tag_ok,
  output logic             err,
  output logic             ciph_load,
  output logic [BLK_W-1:0] ciph_in,
  input  logic             ciph_done,
  input  logic [BLK_W-1:0] ciph_out
);

  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_A     = 3'd2;
  localparam logic [2:0] CMD_FIN_A = 3'd3;
  localparam logic [2:0] CMD_M     = 3'd4;
  localparam logic [2:0] CMD_FIN   = 3'd5;

  // Tag occupies the top TAG_W bits of the final block.
  localparam logic [BLK_W-1:0] TAG_MASK = ~({BLK_W{1'b1}} >> TAG_W);

  typedef enum logic [2:0] {S_IDLE, S_CALL, S_WAIT, S_MIX, S_FINISH} state_t;

  // Micro-step: which cipher call is in flight; selects input, result
  // destination and the step that follows it.
  typedef enum logic [3:0] {
    ST_START, ST_A, ST_FA_H, ST_FA_K, ST_FA_M,
    ST_M_M, ST_M_K, ST_F_M, ST_F_T
  } step_t;

  typedef enum logic [1:0] {PH_NONE, PH_AD, PH_MSG} phase_t;

  state_t state, state_nx;
  step_t  step, step_nx;
  phase_t phase;

  logic             dec;
  logic [BLK_W-1:0] blk;
  logic [NB_W-1:0]  nbytes;
  logic [TAG_W-1:0] tag_exp;
  logic [BLK_W-1:0] h, u, k, m, t;
  logic [LEN_W-1:0] len_a, len_m;
  logic             err_q;

  logic             accept;
  logic             illegal;
  logic             bytes_bad;
  logic             din_nz;
  logic [BLK_W-1:0] mask;
  logic [BLK_W-1:0] c_msg;
  logic [BLK_W-1:0] cin_sel;
  logic [BLK_W-1:0] lena_blk;
  logic [BLK_W-1:0] lenm_blk;

  function automatic logic [BLK_W-1:0] g_fn(input logic [BLK_W-1:0] a);
    return {a[BLK_W-9:0], a[BLK_W-1:BLK_W-8] ^ a[BLK_W-9:BLK_W-16]};
  endfunction

  // Keeps the top n bytes (byte 0 sits at the MSBs).
  function automatic logic [BLK_W-1:0] byte_mask(input logic [NB_W-1:0] n);
    logic [BLK_W-1:0] mk;
    mk = '0;
    for (int i = 0; i < BLK_W / 8; i++) begin
      if (i < int'(n)) mk[BLK_W-1-8*i -: 8] = 8'hFF;
    end
    return mk;
  endfunction

  // Length counters folded into a block: truncate or zero-extend.
  generate
    if (LEN_W >= BLK_W) begin : g_len_trunc
      assign lena_blk = len_a[BLK_W-1:0];
      assign lenm_blk = len_m[BLK_W-1:0];
    end else begin : g_len_ext
      assign lena_blk = {{(BLK_W-LEN_W){1'b0}}, len_a};
      assign lenm_blk = {{(BLK_W-LEN_W){1'b0}}, len_m};
    end
  endgenerate

  assign accept    = cmd_valid && (state == S_IDLE);
  assign bytes_bad = 32'(din_bytes) > 32'(BLK_W / 8);
  assign din_nz    = (din_bytes != '0);
  assign mask      = byte_mask(nbytes);
  assign c_msg     = dec ? blk : (k ^ blk);

  // Command legality against the current phase and byte count.
  always_comb begin
    illegal = 1'b0;
    case (cmd)
      CMD_A:     illegal = (phase != PH_AD);
      CMD_FIN_A: illegal = (phase != PH_AD) || bytes_bad;
      CMD_M:     illegal = (phase != PH_MSG);
      CMD_FIN:   illegal = (phase != PH_MSG) || bytes_bad;
      3'd6, 3'd7: illegal = 1'b1;
      default:   illegal = 1'b0;
    endcase
  end

  // FSM state and micro-step register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      step  <= ST_START;
    end else begin
      state <= state_nx;
      step  <= step_nx;
    end
  end

  // Next-state logic: command dispatch and call chaining.
  always_comb begin
    state_nx = state;
    step_nx  = step;
    case (state)
      S_IDLE: begin
        if (accept && !illegal) begin
          case (cmd)
            CMD_START: begin step_nx = ST_START; state_nx = S_CALL; end
            CMD_A:     begin step_nx = ST_A;     state_nx = S_CALL; end
            CMD_FIN_A: begin
              if (din_nz) begin step_nx = ST_FA_H; state_nx = S_CALL; end
              else        state_nx = S_MIX;
            end
            CMD_M:     begin step_nx = ST_M_M;   state_nx = S_CALL; end
            CMD_FIN:   begin
              step_nx  = din_nz ? ST_F_M : ST_F_T;
              state_nx = S_CALL;
            end
            default: state_nx = S_IDLE;
          endcase
        end
      end
      S_CALL: state_nx = S_WAIT;
      S_WAIT: begin
        if (ciph_done) begin
          case (step)
            ST_FA_H: state_nx = S_MIX;
            ST_FA_K: begin step_nx = ST_FA_M; state_nx = S_CALL; end
            ST_M_M:  begin step_nx = ST_M_K;  state_nx = S_CALL; end
            ST_F_M:  begin step_nx = ST_F_T;  state_nx = S_CALL; end
            default: state_nx = S_FINISH;
          endcase
        end
      end
      S_MIX:    begin step_nx = ST_FA_K; state_nx = S_CALL; end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Cipher input for the current micro-step.
  always_comb begin
    cin_sel = '0;
    case (step)
      ST_START: cin_sel = blk;
      ST_A:     cin_sel = h ^ blk;
      ST_FA_H:  cin_sel = h ^ (blk & mask);
      ST_FA_K:  cin_sel = u;
      ST_FA_M:  cin_sel = g_fn(u);
      ST_M_M:   cin_sel = m ^ c_msg;
      ST_M_K:   cin_sel = g_fn(k);
      ST_F_M:   cin_sel = m ^ (c_msg & mask);
      ST_F_T:   cin_sel = g_fn(m ^ lenm_blk);
      default:  cin_sel = '0;
    endcase
  end

  // Output decode from state, step and datapath registers.
  always_comb begin
    cmd_ready  = (state == S_IDLE);
    ciph_load  = (state == S_CALL);
    ciph_in    = (state == S_CALL) ? cin_sel : '0;
    done       = (state == S_FINISH);
    err        = err_q;
    dout       = '0;
    dout_valid = 1'b0;
    tag_ok     = 1'b0;
    if (state == S_CALL && step == ST_M_M) begin
      dout       = k ^ blk;
      dout_valid = 1'b1;
    end else if (state == S_CALL && step == ST_F_M) begin
      dout       = (k ^ blk) & mask;
      dout_valid = 1'b1;
    end else if (state == S_FINISH && step == ST_F_T) begin
      dout       = t & TAG_MASK;
      dout_valid = 1'b1;
      tag_ok     = dec && (t[BLK_W-1 -: TAG_W] == tag_exp);
    end
  end

  // Datapath: command capture, phase tracking, cipher result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= PH_NONE;
      dec     <= 1'b0;
      blk     <= '0;
      nbytes  <= '0;
      tag_exp <= '0;
      h       <= '0;
      u       <= '0;
      k       <= '0;
      m       <= '0;
      t       <= '0;
      len_a   <= '0;
      len_m   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && illegal;
      if (accept && !illegal) begin
        blk     <= din;
        nbytes  <= din_bytes;
        tag_exp <= tag_in;
        case (cmd)
          CMD_START: begin
            phase <= PH_AD;
            dec   <= decrypt;
            len_a <= '0;
            len_m <= '0;
          end
          CMD_FIN_A: phase <= PH_MSG;
          CMD_FIN:   phase <= PH_NONE;
          default:   phase <= phase;
        endcase
      end
      if (state == S_MIX) u <= g_fn(h ^ lena_blk);
      if (state == S_WAIT && ciph_done) begin
        case (step)
          ST_START: h <= ciph_out;
          ST_A:     begin h <= ciph_out; len_a <= len_a + LEN_W'(BLK_W); end
          ST_FA_H:  begin h <= ciph_out; len_a <= len_a + LEN_W'({nbytes, 3'b000}); end
          ST_FA_K:  k <= ciph_out;
          ST_FA_M:  m <= ciph_out;
          ST_M_M:   m <= ciph_out;
          ST_M_K:   begin k <= ciph_out; len_m <= len_m + LEN_W'(BLK_W); end
          ST_F_M:   begin m <= ciph_out; len_m <= len_m + LEN_W'({nbytes, 3'b000}); end
          ST_F_T:   t <= ciph_out;
          default:  t <= t;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_silc_core_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_silc_core_param
//  Purpose  : Directed self-checking bench for silc_core_param, 64-bit and
//             128-bit/96-bit-tag instances, each with an XOR stub cipher.
//  Revision : 1.0 - initial
// ============================================================================
module tb_silc_core_param;

  localparam logic [63:0]  P64  = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [127:0] P128 = {P64, P64};

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   cmd;
  logic         a_valid, b_valid, decrypt;
  logic [127:0] din;
  logic [4:0]   din_bytes;
  logic [127:0] tag_in;

  logic         a_ready, a_dv, a_done, a_tok, a_err, a_load, a_cdone;
  logic [63:0]  a_dout, a_cin, a_cout, a_buf;
  int           a_cnt;
  logic         b_ready, b_dv, b_done, b_tok, b_err, b_load, b_cdone;
  logic [127:0] b_dout, b_cin, b_cout, b_buf;
  int           b_cnt;

  int checks = 0;
  int failures = 0;

  // results of the most recent command
  int           r_loads, r_dv_cyc, r_err_cyc, r_gap, cd_cyc;
  logic         r_err, r_done, r_tok, r_done_dv;
  logic [127:0] r_dv_first, r_done_dout, r_cin0;

  always #5 clk = ~clk;

  silc_core_param #(.BLK_W(64), .LEN_W(64), .TAG_W(64), .NB_W(4)) dut_a (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .decrypt(decrypt), .din(din[63:0]), .din_bytes(din_bytes[3:0]),
    .tag_in(tag_in[63:0]), .dout(a_dout), .dout_valid(a_dv), .done(a_done),
    .tag_ok(a_tok), .err(a_err), .ciph_load(a_load), .ciph_in(a_cin),
    .ciph_done(a_cdone), .ciph_out(a_cout));

  silc_core_param #(.BLK_W(128), .LEN_W(64), .TAG_W(96), .NB_W(5)) dut_b (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .decrypt(decrypt), .din(din), .din_bytes(din_bytes),
    .tag_in(tag_in[95:0]), .dout(b_dout), .dout_valid(b_dv), .done(b_done),
    .tag_ok(b_tok), .err(b_err), .ciph_load(b_load), .ciph_in(b_cin),
    .ciph_done(b_cdone), .ciph_out(b_cout));

  // Stub ciphers: E(x) = x ^ A5.., result strobe a few cycles after load.
  always @(posedge clk) begin
    if (rst) begin
      a_cnt <= 0; a_cdone <= 1'b0; a_cout <= '0; a_buf <= '0;
      b_cnt <= 0; b_cdone <= 1'b0; b_cout <= '0; b_buf <= '0;
    end else begin
      a_cdone <= 1'b0;
      b_cdone <= 1'b0;
      if (a_load) begin a_buf <= a_cin ^ P64; a_cnt <= 3; end
      else if (a_cnt != 0) begin
        a_cnt <= a_cnt - 1;
        if (a_cnt == 1) begin a_cdone <= 1'b1; a_cout <= a_buf; end
      end
      if (b_load) begin b_buf <= b_cin ^ P128; b_cnt <= 3; end
      else if (b_cnt != 0) begin
        b_cnt <= b_cnt - 1;
        if (b_cnt == 1) begin b_cdone <= 1'b1; b_cout <= b_buf; end
      end
    end
  end

  function automatic logic [63:0] g64(input logic [63:0] a);
    return {a[55:0], a[63:56] ^ a[55:48]};
  endfunction
  function automatic logic [63:0] e64(input logic [63:0] x);
    return x ^ P64;
  endfunction
  function automatic logic [63:0] pad64(input logic [63:0] x, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[63-8*i -: 8] = x[63-8*i -: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command on instance A (wide=0) or B (wide=1) and watch it.
  task automatic run(input bit wide, input logic [2:0] c, input logic [127:0] d,
                     input logic [4:0] nb, input logic [127:0] ti, input int lim);
    logic ld, dv, dn, er, tk, cdn;
    logic [127:0] dq, ci;
    r_loads = 0; r_dv_cyc = -1; r_err_cyc = -1; r_gap = -1; cd_cyc = -1;
    r_err = 0; r_done = 0; r_tok = 0; r_done_dv = 0;
    r_dv_first = '0; r_done_dout = '0; r_cin0 = '0;
    @(negedge clk);
    cmd = c; din = d; din_bytes = nb; tag_in = ti;
    if (wide) b_valid = 1'b1; else a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; cmd = 3'd0;
    for (int i = 0; i < lim; i++) begin
      ld  = wide ? b_load  : a_load;
      dv  = wide ? b_dv    : a_dv;
      dn  = wide ? b_done  : a_done;
      er  = wide ? b_err   : a_err;
      tk  = wide ? b_tok   : a_tok;
      cdn = wide ? b_cdone : a_cdone;
      dq  = wide ? b_dout  : {64'd0, a_dout};
      ci  = wide ? b_cin   : {64'd0, a_cin};
      if (ld) begin
        if (r_loads == 0) r_cin0 = ci;
        r_loads++;
      end
      if (cdn) cd_cyc = i;
      if (dv && !dn && r_dv_cyc < 0) begin r_dv_first = dq; r_dv_cyc = i; end
      if (er && !r_err) begin r_err = 1; r_err_cyc = i; end
      if (dn) begin
        r_done = 1; r_tok = tk; r_done_dv = dv; r_done_dout = dq;
        r_gap = i - cd_cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] n0, ad1, ad2, p1, p2, h, u, k, m, c1, c2, t, lena, lenm;
    rst = 1'b1; cmd = 3'd0; a_valid = 0; b_valid = 0; decrypt = 0;
    din = '0; din_bytes = '0; tag_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", a_ready, 1);
    check("reset_outs", {a_dv, a_done, a_tok, a_err, a_load}, 0);
    check("reset_dout", a_dout, 0);

    // illegal commands in phase NONE
    run(0, 3'd3, 128'd0, 5'd3, 128'd0, 4);
    check("fina_none_err", {r_err, r_err_cyc[3:0]}, {1'b1, 4'd0});
    check("fina_none_noload", {r_loads[3:0], r_done}, 0);
    run(0, 3'd7, 128'd0, 5'd0, 128'd0, 4);
    check("cmd7_err", {r_err, r_loads[3:0], r_done}, {1'b1, 4'd0, 1'b0});

    // START din=0 -> H = A5..; observed through the next A call input
    run(0, 3'd1, 128'd0, 5'd0, 128'd0, 60);
    check("start_loads", r_loads, 1);
    check("start_done_gap", r_gap, 1);
    check("start_cin", r_cin0, 0);
    run(0, 3'd2, 128'd0, 5'd0, 128'd0, 60);
    check("a_cin_h", r_cin0, {64'd0, P64});
    run(0, 3'd4, 128'd0, 5'd0, 128'd0, 4);
    check("m_in_ad_err", {r_err, r_loads[3:0], r_done}, {1'b1, 4'd0, 1'b0});

    // g check: H ^ lenA = 0102030405060708, empty AD
    run(0, 3'd1, {64'd0, 64'h0102030405060708 ^ P64}, 5'd0, 128'd0, 60);
    run(0, 3'd3, 128'd0, 5'd0, 128'd0, 80);
    check("g_mix_u", r_cin0, {64'd0, 64'h0203040506070803});
    check("fina0_loads", r_loads, 2);

    // reference session
    n0 = 64'h0123456789ABCDEF; ad1 = 64'h1111111111111111;
    ad2 = 64'h2233445566778899; p1 = 64'h0011223344556677;
    p2 = 64'h8899AABBCCDDEEFF;
    h = e64(n0); h = e64(h ^ ad1); h = e64(h ^ pad64(ad2, 3)); lena = 64'd88;
    u = g64(h ^ lena); k = e64(u); m = e64(g64(u));
    c1 = k ^ p1; m = e64(m ^ c1); k = e64(g64(k));
    c2 = pad64(k ^ p2, 5); m = e64(m ^ c2); lenm = 64'd104;
    t = e64(g64(m ^ lenm));

    // encrypt
    decrypt = 0;
    run(0, 3'd1, {64'd0, n0}, 5'd0, 128'd0, 60);
    run(0, 3'd2, {64'd0, ad1}, 5'd0, 128'd0, 60);
    run(0, 3'd3, {64'd0, ad2}, 5'd3, 128'd0, 120);
    check("fina3_loads", r_loads, 3);
    run(0, 3'd4, {64'd0, p1}, 5'd0, 128'd0, 80);
    check("enc_m_dout", r_dv_first, {64'd0, c1});
    check("enc_m_dv_cyc", r_dv_cyc, 0);
    run(0, 3'd5, {64'd0, p2}, 5'd5, 128'd0, 80);
    check("enc_fin_dout", r_dv_first, {64'd0, c2});
    check("enc_tag", {r_done, r_done_dv, r_done_dout}, {1'b1, 1'b1, 64'd0, t});
    check("enc_tag_ok", r_tok, 0);

    // decrypt with correct and with corrupted tag
    for (int pass = 0; pass < 2; pass++) begin
      decrypt = 1;
      run(0, 3'd1, {64'd0, n0}, 5'd0, 128'd0, 60);
      run(0, 3'd2, {64'd0, ad1}, 5'd0, 128'd0, 60);
      run(0, 3'd3, {64'd0, ad2}, 5'd3, 128'd0, 120);
      run(0, 3'd4, {64'd0, c1}, 5'd0, 128'd0, 80);
      check("dec_m_plain", r_dv_first, {64'd0, p1});
      run(0, 3'd5, {64'd0, c2}, 5'd5, {64'd0, (pass == 0) ? t : (t ^ 64'd1)}, 80);
      check("dec_fin_plain", r_dv_first, {64'd0, pad64(p2, 5)});
      check("dec_tag", {r_done, r_done_dout}, {1'b1, 64'd0, t});
      check("dec_tag_ok", r_tok, (pass == 0) ? 1'b1 : 1'b0);
    end

    // 128-bit block, 96-bit tag, empty AD and message
    for (int pass = 0; pass < 2; pass++) begin
      decrypt = 1;
      run(1, 3'd1, 128'd0, 5'd0, 128'd0, 60);
      run(1, 3'd3, 128'd0, 5'd0, 128'd0, 80);
      run(1, 3'd5, 128'd0, 5'd0,
          {32'd0, 96'hA5A5A5A5_A5A5A5A5_A5A5A5A5 ^ ((pass == 0) ? 96'd0 : 96'd1)}, 80);
      check("w_tag", {r_done, r_done_dv, r_done_dout},
            {2'b11, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_00000000});
      check("w_tag_ok", r_tok, (pass == 0) ? 1'b1 : 1'b0);
    end
    check("w_err_none", r_err, 0);

    // reset while the M call is outstanding
    decrypt = 0;
    run(0, 3'd1, 128'd0, 5'd0, 128'd0, 60);
    run(0, 3'd3, 128'd0, 5'd0, 128'd0, 80);
    @(negedge clk);
    cmd = 3'd4; din = 128'd5; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; cmd = 3'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", a_ready, 1);
    check("rst_outs", {a_dv, a_done, a_tok, a_err, a_load, a_dout, a_cin}, 0);
    run(0, 3'd4, 128'd5, 5'd0, 128'd0, 4);
    check("rst_m_err", {r_err, r_loads[3:0], r_done}, {1'b1, 4'd0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
